hilo_muldiv: RTL

- Parametrised HI/LO multiply/divide unit for the MIPS datapath; it owns the HI and LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and exposes HI/LO continuously for MFHI/MFLO.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy.
- Adds behaviour the combinational decoder lacks: multi-cycle multiply (configurable latency), iterative division, flush, and divide-by-zero reporting.

---
 rtl/hilo_muldiv.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: pipelined-latency multiply, restoring divide,
// MTHI/MTLO writes, flush and divide-by-zero reporting.
module hilo_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   opa_r, opb_r, quo_r, rem_r, dvs_r;
  logic               sgn_r, qneg_r, rneg_r, bzero_r;
  logic               mul_wr_s, div_wr_s, mthi_s, mtlo_s, start_mul_s, start_div_s;
  logic [2*WIDTH-1:0] ax_s, bx_s, prod_s;
  logic [WIDTH:0]     rem_sh_s, trial_s;
  logic [WIDTH-1:0]   q_fix_s, r_fix_s, abs_a_s, abs_b_s;
  logic               a_neg_s, b_neg_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? (~v + WIDTH'(1'b1)) : v;
  endfunction

  // Next-state and write strobes
  always_comb begin
    state_s     = state_r;
    mul_wr_s    = 1'b0;
    div_wr_s    = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    start_mul_s = 1'b0;
    start_div_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (op_valid && !flush) begin
          case (op)
            3'b000, 3'b001: begin start_mul_s = 1'b1; state_s = MUL; end
            3'b010, 3'b011: begin start_div_s = 1'b1; state_s = DIV; end
            3'b100:         mthi_s = 1'b1;
            3'b101:         mtlo_s = 1'b1;
            default:        state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (flush) begin
          state_s = IDLE;
        end else if (cnt_r == CW'(MUL_LAT)) begin
          mul_wr_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s = MUL;
        end
      end
      DIV: begin
        if (flush) begin
          state_s = IDLE;
        end else if (cnt_r == CW'(WIDTH - 1)) begin
          state_s = FIX;
        end else begin
          state_s = DIV;
        end
      end
      FIX: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          div_wr_s = 1'b1;
          state_s  = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: product, one restoring step, sign fix-up, operand magnitudes
  always_comb begin
    ax_s     = sgn_r ? {{WIDTH{opa_r[WIDTH-1]}}, opa_r} : {{WIDTH{1'b0}}, opa_r};
    bx_s     = sgn_r ? {{WIDTH{opb_r[WIDTH-1]}}, opb_r} : {{WIDTH{1'b0}}, opb_r};
    prod_s   = ax_s * bx_s;
    rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    trial_s  = rem_sh_s - {1'b0, dvs_r};
    q_fix_s  = cond_neg(quo_r, qneg_r);
    r_fix_s  = cond_neg(rem_r, rneg_r);
    a_neg_s  = !op[0] && a[WIDTH-1];
    b_neg_s  = !op[0] && b[WIDTH-1];
    abs_a_s  = cond_neg(a, a_neg_s);
    abs_b_s  = cond_neg(b, b_neg_s);
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Operand latches, iteration state, HI/LO and status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r    <= {CW{1'b0}};
      opa_r    <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      sgn_r    <= 1'b0;
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
      bzero_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      busy     <= (state_s != IDLE);
      done     <= mul_wr_s | div_wr_s | mthi_s | mtlo_s;
      div_zero <= div_wr_s & bzero_r;
      if (start_mul_s) begin
        opa_r <= a;
        opb_r <= b;
        sgn_r <= ~op[0];
        cnt_r <= CW'(1);
      end else if (start_div_s) begin
        opa_r   <= a;
        quo_r   <= abs_a_s;
        dvs_r   <= abs_b_s;
        rem_r   <= {WIDTH{1'b0}};
        qneg_r  <= a_neg_s ^ b_neg_s;
        rneg_r  <= a_neg_s;
        bzero_r <= (b == {WIDTH{1'b0}});
        cnt_r   <= {CW{1'b0}};
      end else if (state_r == MUL) begin
        cnt_r <= cnt_r + CW'(1);
      end else if (state_r == DIV) begin
        cnt_r <= cnt_r + CW'(1);
        // A clear borrow bit means the divisor fits: keep the difference
        if (!trial_s[WIDTH]) begin
          rem_r <= trial_s[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], 1'b1};
        end else begin
          rem_r <= rem_sh_s[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], 1'b0};
        end
      end
      if (mthi_s) hi <= a;
      if (mtlo_s) lo <= a;
      if (mul_wr_s) {hi, lo} <= prod_s;
      if (div_wr_s) begin
        if (bzero_r) begin
          hi <= opa_r;
          lo <= {WIDTH{1'b1}};
        end else begin
          hi <= r_fix_s;
          lo <= q_fix_s;
        end
      end
    end
  end

endmodule
